// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port
// between NUM_REQ producers, gated by the FIFO's registered full flag.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic [IW-1:0] rr_ptr, rr_ptr_nx, grant_id_nx, pick;
    logic [7:0] beat_cnt, beat_cnt_nx;
    logic found;
    int idx;
    // first valid requester at or above rr_ptr, wrapping
    always_comb begin
        pick = rr_ptr;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[IW'(idx)]) begin
                found = 1'b1;
                pick = IW'(idx);
            end
        end
    end
    // rst also blocks the write so a beat in flight at reset is never committed
    always_comb begin
        grant_valid = state == BURST;
        req_ready = '0;
        req_ready[grant_id] = grant_valid & !fifo_full & !rst;
        fifo_wr_en = grant_valid & req_valid[grant_id] & !fifo_full & !rst;
        fifo_data_in = grant_valid ? req_data[grant_id*WIDTH +: WIDTH] : '0;
    end
    always_comb begin
        state_nx = state;
        rr_ptr_nx = rr_ptr;
        grant_id_nx = grant_id;
        beat_cnt_nx = beat_cnt;
        if (state == IDLE) begin
            if (found) begin
                state_nx = BURST;
                grant_id_nx = pick;
                beat_cnt_nx = '0;
            end
        end else begin
            beat_cnt_nx = beat_cnt + 8'(fifo_wr_en);
            if ((fifo_wr_en && (req_last[grant_id] || beat_cnt == 8'(MAX_BURST-1))) || !req_valid[grant_id]) begin
                state_nx = IDLE;
                rr_ptr_nx = (grant_id == IW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            state <= state_nx;
            rr_ptr <= rr_ptr_nx;
            beat_cnt <= beat_cnt_nx;
            grant_id <= grant_id_nx;
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's synchronous FIFO between NUM_REQ producers.
- Round-robin arbitration with burst grants: a winner keeps the port for up to MAX_BURST beats or until it ends its packet.
- Drives the FIFO's wr_en and data_in and observes its registered full flag; no write is ever issued while full is high.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 8, data width; matches the FIFO WIDTH
- MAX_BURST, 4, maximum beats per grant (1..255)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester data valid
- req_last  input  NUM_REQ  per-requester last beat of packet; qualified by valid
- req_data  input  NUM_REQ*WIDTH  flattened data; requester i at bits [i*WIDTH +: WIDTH]
- req_ready  output  NUM_REQ  per-requester accept; beat transfers when valid & ready
- fifo_full  input  1  FIFO full flag (registered in FIFO)
- fifo_wr_en  output  1  FIFO write enable
- fifo_data_in  output  WIDTH  FIFO write data
- grant_valid  output  1  a burst grant is active
- grant_id  output  $clog2(NUM_REQ)  index of granted requester

Behaviour:
- Reset: state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0. grant_valid, req_ready, fifo_wr_en are 0; fifo_data_in is 0 while no grant.
- FSM has two states, IDLE and BURST.
- IDLE, arbitration:
  - If any req_valid, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register grant_id, clear beat_cnt, go to BURST.
  - Arbitration latency is 1 cycle: no transfers occur in IDLE.
- BURST, outputs (g = grant_id):
  - req_ready[g] = !fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] & !fifo_full.
  - fifo_data_in = req_data[g] (combinational mux).
- Transfer: req_valid[g] & req_ready[g]. Each transfer increments beat_cnt (8-bit).
- BURST exits to IDLE at the clock edge when any of these holds:
  - (a) transfer with req_last[g]=1
  - (b) transfer with beat_cnt == MAX_BURST-1
  - (c) req_valid[g]=0 (abandon; no beat written)
- On every exit: rr_ptr <= (g+1) mod NUM_REQ.
- IDLE gap: at least one IDLE cycle separates bursts, including when the same requester wins again.
- fifo_full=1 during BURST: stall and hold the grant indefinitely, with no timeout. Because fifo_full is registered, gating on it guarantees no dropped writes. Condition (c) is still evaluated while stalled.
- req_last with no transfer (full stall): no exit; the burst waits for the beat.
- Simultaneous requests: only rr_ptr order matters. Lower index has no fixed priority.
- Single requester: it is re-granted after each exit, one IDLE cycle apart.
- rst mid-burst: any pending beat is not written, the FSM returns to IDLE, and rr_ptr returns to 0. The requester must re-present its data.
- Data is never reordered within a requester. Interleaving between requesters occurs only at burst boundaries.

Test Plan:
- Single requester, MAX_BURST=4: req_valid[1] held high with 10 beats 0x10..0x19, fifo never full.
  - FIFO receives 0x10..0x19 in order.
  - Bursts run 4,4,2 beats, each separated by one IDLE cycle with grant_valid=0.
- All 4 requesters valid continuously, rr_ptr=0 after reset: grant order is 0,1,2,3,0. Each burst is 4 beats; fifo_wr_en=0 only in the IDLE cycles.
- Requester 2 sends 0xA0,0xA1 with req_last on 0xA1, while requester 3 is valid:
  - Burst ends after 2 beats.
  - Next grant_id=3.
  - FIFO contents are 0xA0,0xA1, then requester 3's data.
- Force fifo_full=1 for 5 cycles mid-burst on beat 0xB2:
  - req_ready and fifo_wr_en are 0 for those 5 cycles; grant is held.
  - 0xB2 is written exactly once after full drops.
  - Total beats in the burst still equal 4.
- Requester 0 drops req_valid after 1 beat: exit to IDLE with no extra write; next grant goes to the next valid index above 0.
- Assert rst for 1 cycle during a granted beat: that beat is not written; outputs are 0 next cycle; the first grant after reset follows rr_ptr=0 order.
